mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_wait_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF         = 32;
   localparam int DATA_W_DEF         = 32;
   localparam int TIMEOUT_CYCLES_DEF = 16;
   localparam int STARVE_LIMIT_DEF   = 4;
   localparam int CNT_W              = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Bus wait counter: cleared outside an access, counts access cycles and flags
// expiry on the TIMEOUT_CYCLES-th cycle without an acknowledge.
module arb_wait_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic count_i,
   output logic expire_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // count_q is the number of access cycles already elapsed before this one
   assign expire_o = count_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_i && !expire_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory bus.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ready_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              stall_o,
   output logic              err_o,
   output arb_state_e        state_o
);

   // Handshake: a port holds req (and its address/data) until its ready pulses
   // for one cycle; the bus holds req and payload stable until ack (or timeout).

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES outside 2..255");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
      $error("STARVE_LIMIT outside 1..255");
   end

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              we_q, we_d;
   logic              grant_data_q, grant_data_d;
   logic              err_q, err_d;
   logic              busy, expire, starve_hit, take_data, take_fetch;

   assign busy = (state_q == DATA) || (state_q == FETCH);

`ifdef ARB_STARVE_GUARD_EN
   logic [CNT_W-1:0] starve_q, starve_d;

   assign starve_hit = if_req_i && (starve_q >= CNT_W'(STARVE_LIMIT));

   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (take_data && if_req_i && (starve_q != '1)) begin
            starve_d = starve_q + 1'b1;
         end else if (take_fetch) begin
            starve_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   assign take_data  = dm_req_i && !starve_hit;
   assign take_fetch = if_req_i && !take_data;

   arb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!busy),
      .count_i (busy),
      .expire_o(expire)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      grant_data_d = grant_data_q;
      err_d        = err_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (take_data) begin
               state_d      = DATA;
               grant_data_d = 1'b1;
               addr_d       = dm_addr_i;
               we_d         = dm_we_i;
               wdata_d      = dm_wdata_i;
            end else if (take_fetch) begin
               state_d      = FETCH;
               grant_data_d = 1'b0;
               addr_d       = if_addr_i;
               we_d         = 1'b0;
               wdata_d      = '0;
            end
         end
         DATA, FETCH: begin
            // Ack takes precedence over a timeout expiring in the same cycle
            if (bus_ack_i) begin
               state_d = DONE;
               err_d   = 1'b0;
               if (state_q == FETCH) begin
                  if_rdata_d = bus_rdata_i;
               end else if (!we_q) begin
                  dm_rdata_d = bus_rdata_i;
               end
            end else if (expire) begin
               state_d = DONE;
               err_d   = 1'b1;
               if (state_q == FETCH) begin
                  if_rdata_d = '0;
               end else if (!we_q) begin
                  dm_rdata_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         grant_data_q <= 1'b0;
         err_q        <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         grant_data_q <= grant_data_d;
         err_q        <= err_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   assign bus_req_o   = busy;
   assign bus_we_o    = (state_q == DATA) && we_q;
   assign bus_addr_o  = addr_q;
   assign bus_wdata_o = wdata_q;
   assign if_ready_o  = (state_q == DONE) && !grant_data_q;
   assign dm_ready_o  = (state_q == DONE) && grant_data_q;
   assign err_o       = (state_q == DONE) && err_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);
   assign state_o     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with an rdata scoreboard.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req_i, dm_req_i, dm_we_i, bus_ack_i;
   logic [AW-1:0] if_addr_i, dm_addr_i;
   logic [DW-1:0] dm_wdata_i, bus_rdata_i;
   logic [DW-1:0] if_rdata_o, dm_rdata_o, bus_wdata_o;
   logic [AW-1:0] bus_addr_o;
   logic          if_ready_o, dm_ready_o, bus_req_o, bus_we_o, stall_o, err_o;
   arb_state_e    state_o;

   logic [DW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc;
   logic [DW-1:0] if_model, dm_model, rd;
   bit            is_fetch;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
      .stall_o(stall_o), .err_o(err_o), .state_o(state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus slave: waits for the grant, checks the payload every access cycle,
   // acks on access cycle ack_cyc (0 = never). Returns with the DUT in DONE.
   task automatic serve_bus(input int ack_cyc, input logic [DW-1:0] rdata, input logic exp_we,
                            input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                            output int n_cyc);
      int n;
      n = 0;
      tick();
      while (!bus_req_o && n < 8) begin
         chk("stall_wait", stall_o, 1'b1);
         tick();
         n++;
      end
      chk("grant_seen", bus_req_o, 1'b1);
      n_cyc = 0;
      while (bus_req_o && n_cyc < 300) begin
         n_cyc++;
         chk("bus_addr", bus_addr_o, exp_addr);
         chk("bus_we", bus_we_o, exp_we);
         if (exp_we) chk("bus_wdata", bus_wdata_o, exp_wdata);
         chk("stall_busy", stall_o, 1'b1);
         if (n_cyc == ack_cyc) begin
            bus_ack_i   = 1'b1;
            bus_rdata_i = rdata;
         end
         tick();
         bus_ack_i   = 1'b0;
         bus_rdata_i = $urandom;
      end
   endtask

   task automatic expect_done(input bit data, input bit err);
      logic [DW-1:0] e;
      chk("state_done", state_o, DONE);
      chk("if_ready", if_ready_o, !data);
      chk("dm_ready", dm_ready_o, data);
      chk("err", err_o, err);
      chk("bus_req_done", bus_req_o, 1'b0);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
         e = exp_q.pop_front();
         chk(data ? "dm_rdata" : "if_rdata", data ? dm_rdata_o : if_rdata_o, e);
      end
   endtask

   initial begin
      reset = 1'b1;
      if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; bus_ack_i = 1'b0;
      if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; bus_rdata_i = '0;
      if_model = '0; dm_model = '0;
      tick();
      tick();
      chk("rst_state", state_o, IDLE);
      chk("rst_bus_req", bus_req_o, 1'b0);
      chk("rst_bus_we", bus_we_o, 1'b0);
      chk("rst_bus_addr", bus_addr_o, '0);
      chk("rst_bus_wdata", bus_wdata_o, '0);
      chk("rst_if_ready", if_ready_o, 1'b0);
      chk("rst_dm_ready", dm_ready_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_if_rdata", if_rdata_o, '0);
      chk("rst_dm_rdata", dm_rdata_o, '0);
      chk("rst_stall", stall_o, 1'b0);
      reset = 1'b0;
      tick();

      // fetch 0x100, ack on second bus cycle
      if_req_i = 1'b1; if_addr_i = 32'h100;
      if_model = 32'h0000_0013;
      exp_q.push_back(if_model);
      #1 chk("fetch_stall_req", stall_o, 1'b1);
      serve_bus(2, 32'h0000_0013, 1'b0, 32'h100, '0, cyc);
      chk("fetch_cycles", cyc, 2);
      expect_done(1'b0, 1'b0);
      chk("fetch_stall_ready", stall_o, 1'b0);
      if_req_i = 1'b0;
      tick();
      chk("fetch_pulse_end", if_ready_o, 1'b0);
      chk("fetch_idle", state_o, IDLE);
      chk("fetch_hold", if_rdata_o, if_model);

      // simultaneous fetch and load: data wins, then the fetch
      if_req_i = 1'b1; if_addr_i = 32'h180;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2000;
      dm_model = 32'hCAFE_0001;
      exp_q.push_back(dm_model);
      exp_q.push_back(32'h0BAD_F00D);
      #1 chk("both_stall", stall_o, 1'b1);
      serve_bus(1, dm_model, 1'b0, 32'h2000, '0, cyc);
      expect_done(1'b1, 1'b0);
      chk("both_stall_fetch_wait", stall_o, 1'b1);
      dm_req_i = 1'b0;
      serve_bus(2, 32'h0BAD_F00D, 1'b0, 32'h180, '0, cyc);
      expect_done(1'b0, 1'b0);
      if_model = 32'h0BAD_F00D;
      if_req_i = 1'b0;
      tick();

      // store: payload stable until ack, load data register untouched
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = 32'hDEAD_BEEF;
      exp_q.push_back(dm_model);
      serve_bus(3, 32'h5555_5555, 1'b1, 32'h40, 32'hDEAD_BEEF, cyc);
      chk("store_cycles", cyc, 3);
      expect_done(1'b1, 1'b0);
      dm_req_i = 1'b0; dm_we_i = 1'b0;
      tick();
      chk("store_bus_we_off", bus_we_o, 1'b0);

      // fetch never acked: timeout after TO cycles, err pulse, rdata zero
      if_req_i = 1'b1; if_addr_i = 32'h300;
      if_model = '0;
      exp_q.push_back(if_model);
      serve_bus(0, '0, 1'b0, 32'h300, '0, cyc);
      chk("timeout_cycles", cyc, TO);
      expect_done(1'b0, 1'b1);
      if_req_i = 1'b0;
      tick();
      chk("timeout_err_end", err_o, 1'b0);
      chk("timeout_ready_end", if_ready_o, 1'b0);

      // ack on the last allowed cycle: no error
      dm_req_i = 1'b1; dm_addr_i = 32'h800;
      dm_model = 32'hA5A5_A5A5;
      exp_q.push_back(dm_model);
      serve_bus(TO, dm_model, 1'b0, 32'h800, '0, cyc);
      chk("ack_last_cycles", cyc, TO);
      expect_done(1'b1, 1'b0);
      dm_req_i = 1'b0;
      tick();

      // reset after three wait cycles in DATA
      dm_req_i = 1'b1; dm_addr_i = 32'h500;
      tick();
      chk("rst_mid_data", state_o, DATA);
      tick();
      tick();
      reset = 1'b1;
      chk("rst_mid_bus_still", bus_req_o, 1'b1);
      tick();
      chk("rst_mid_bus_req", bus_req_o, 1'b0);
      chk("rst_mid_dm_ready", dm_ready_o, 1'b0);
      chk("rst_mid_state", state_o, IDLE);
      chk("rst_mid_dm_rdata", dm_rdata_o, '0);
      chk("rst_mid_if_rdata", if_rdata_o, '0);
      dm_req_i = 1'b0;
      reset = 1'b0;
      tick();
      chk("rst_mid_no_pulse", dm_ready_o, 1'b0);
      chk("rst_mid_idle", state_o, IDLE);

      // both ports held: starvation guard decides whether the fifth grant is a fetch
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h600;
      if_req_i = 1'b1; if_addr_i = 32'h700;
      for (int i = 0; i < 5; i++) begin
         is_fetch = STARVE_EN && (i == 4);
         rd = $urandom;
         exp_q.push_back(rd);
         serve_bus(1, rd, 1'b0, is_fetch ? 32'h700 : 32'h600, '0, cyc);
         expect_done(!is_fetch, 1'b0);
      end
      dm_req_i = 1'b0; if_req_i = 1'b0;
      tick();
      tick();
      chk("final_idle", state_o, IDLE);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
